mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit.
- Sequences the shared datapath (ALU, register file, unified memory, PC/IR registers) through Fetch/Decode/Execute/Memory/Writeback states.
- Drives the select lines of the write-data mux, write-address mux and ALU-B mux, plus all write enables.
- Sits beside the datapath top; consumes IR fields and the ALU zero flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU equality flag (rs==rt), valid in EXEC
- ir_we  output  1  latch instruction register
- pc_we  output  1  load PC from NPC mux
- npc_sel  output  2  00 PC+4, 01 branch target, 10 jump target {PC[31:28],imm26,00}, 11 rs (jr)
- reg_we  output  1  register file write enable
- mem_we  output  1  data memory write enable
- wd_sel  output  2  write-data mux: 00 ALU result, 01 memory data, 10 PC register (holds PC+4), 11 zero-extended ALU less flag
- wa_sel  output  2  write-address mux: 00 rt, 01 rd, 10 constant 31
- alu_b_sel  output  1  0 rt data, 1 extended immediate
- ext_sel  output  1  0 zero-extend, 1 sign-extend
- alu_op  output  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
- illegal  output  1  one-cycle pulse on undecodable instruction
- retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset:
  - Synchronous, active-high. Applies on a rising clk edge with reset=1.
  - state=FETCH, retired=0.
  - While reset=1, ir_we, pc_we, reg_we, mem_we and illegal are forced to 0. All selects are 0.
- Output timing:
  - State is registered.
  - Outputs are combinational decode of {state, opcode, funct, zero}. IR is stable after FETCH.
  - Unlisted outputs are 0 in every state.
- Supported instructions:
  - R-type (op 000000): addu 100001, subu 100011, slt 101010, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH: ir_we=1, pc_we=1, npc_sel=00. Next state is DECODE.
- DECODE:
  - j: pc_we=1, npc_sel=10 -> FETCH.
  - jal: pc_we=1, npc_sel=10, reg_we=1, wa_sel=10, wd_sel=10 -> FETCH. The PC register still holds PC+4 during this cycle, so $31 gets the link value.
  - jr: pc_we=1, npc_sel=11 -> FETCH.
  - Undecodable opcode, or R-type with unknown funct: illegal=1 -> FETCH. No architectural write.
  - All others -> EXEC.
- EXEC:
  - beq: alu_op=001, ext_sel=1, npc_sel=01, pc_we=zero -> FETCH.
  - lw/sw: alu_b_sel=1, ext_sel=1, alu_op=000 -> MEM.
  - R-type/ori/lui: alu_op per instruction; ori/lui take alu_b_sel=1, ext_sel=0 -> WB.
- MEM:
  - sw: mem_we=1 -> FETCH.
  - lw: -> WB. Memory data is captured by the datapath MDR.
- WB:
  - reg_we=1.
  - wa_sel=01 for R-type, 00 otherwise.
  - wd_sel: 00 for addu/subu/ori/lui, 11 for slt (alu_op=001 held), 01 for lw.
  - Next state is FETCH.
- EXEC-stage ALU controls (alu_op, alu_b_sel, ext_sel) are held through MEM and WB so the ALU result stays stable.
- Latency in cycles:
  - j/jr/jal/illegal: 2
  - beq: 3
  - R-type/ori/lui/sw: 4
  - lw: 5
- Retired counter:
  - Increments by 1 on the last cycle of each legal instruction, i.e. on any transition into FETCH from DECODE/EXEC/MEM/WB when illegal=0.
  - Wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts it: no enable pulses, and the counter does not increment.

Decomposition:
- Shared package mc_pkg holds:
  - state encoding (FETCH, DECODE, EXEC, MEM, WB as 3-bit localparams)
  - opcode and funct constants
  - wd_sel/wa_sel/npc_sel/alu_op encodings, shared with the datapath muxes
- One sub-module, mc_decode: combinational classify of opcode/funct into an instruction-class one-hot plus a legal flag. mc_ctrl holds only the FSM and counter.

Test Plan:
- Reset held 3 cycles, release, feed addu (000000/100001) -> FETCH, DECODE, EXEC, WB over 4 cycles. WB has reg_we=1, wa_sel=01, wd_sel=00. retired=1.
- lw (100011) -> 5 cycles. EXEC has alu_b_sel=1, ext_sel=1. MEM has mem_we=0. WB has wd_sel=01, wa_sel=00.
- beq with zero=1, then zero=0 -> both take 3 cycles. EXEC has npc_sel=01; pc_we=1 on the first and 0 on the second. retired increments both times.
- jal (000011) -> DECODE has pc_we=1, npc_sel=10, reg_we=1, wa_sel=10, wd_sel=10. Next cycle is FETCH.
- opcode 111111 -> illegal pulses 1 cycle in DECODE, no enables, retired unchanged. slt in WB gives wd_sel=11.
- reset asserted in MEM of sw -> mem_we stays 0, state=FETCH next cycle, retired=0. Retired counter with CNT_W=4 wraps 15 -> 0 after 16 instructions.

Source files
------------

// File: rtl/mc_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control unit and its datapath muxes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: FSM state type, opcode/funct constants, mux select encodings, instruction class one-hot.
package mc_pkg;

    // One state per datapath phase, 3-bit encoded.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;
    localparam logic [1:0] WD_LESS  = 2'b11;

    localparam logic [1:0] WA_RT    = 2'b00;
    localparam logic [1:0] WA_RD    = 2'b01;
    localparam logic [1:0] WA_R31   = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    // Exactly one bit set for a supported instruction, all zero otherwise.
    typedef struct packed {
        logic addu;
        logic subu;
        logic slt;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } icls_t;

endpackage

// File: rtl/mc_if.sv
// Purpose: bundle of IR fields / ALU flag in and control lines out between controller and datapath.
// Latency: n/a (wires only).
// Backpressure: none; master = controller, slave = datapath.
// Signals: opcode/funct/zero from datapath; enables, mux selects, ALU controls, illegal, retired to datapath.
interface mc_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       npc_sel;
    logic             reg_we;
    logic             mem_we;
    logic [1:0]       wd_sel;
    logic [1:0]       wa_sel;
    logic             alu_b_sel;
    logic             ext_sel;
    logic [2:0]       alu_op;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero,
        output ir_we, pc_we, npc_sel, reg_we, mem_we, wd_sel, wa_sel,
               alu_b_sel, ext_sel, alu_op, illegal, retired
    );

    modport slave (
        output opcode, funct, zero,
        input  ir_we, pc_we, npc_sel, reg_we, mem_we, wd_sel, wa_sel,
               alu_b_sel, ext_sel, alu_op, illegal, retired
    );
endinterface

// File: rtl/mc_decode.sv
// Purpose: classify opcode/funct into a one-hot instruction class plus legal flag.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode, funct in; cls (icls_t one-hot), legal out.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output icls_t      cls,
    output logic       legal
);
    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_SLT:  cls.slt  = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: ;
        endcase
    end

    assign legal = |cls;
endmodule

// File: rtl/mc_ctrl.sv
// Purpose: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) plus retired-instruction counter.
// Latency: j/jr/jal/illegal 2, beq 3, R-type/ori/lui/sw 4, lw 5 cycles; outputs combinational from state+IR.
// Backpressure: none; datapath is assumed to complete every phase in one cycle.
// Ports: clk, reset (sync, active-high); bus (mc_if.master): IR fields/zero in, enables/selects/illegal/retired out.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic  clk,
    input  logic  reset,
    mc_if.master  bus
);
    state_t           state;
    state_t           state_nxt;
    icls_t            cls;
    logic             legal;
    logic             retire;
    logic [CNT_W-1:0] retired_q;
    logic             rtype;
    logic [2:0]       alu_op_i;
    logic             alu_b_i;
    logic             ext_i;

    mc_decode u_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .cls    (cls),
        .legal  (legal)
    );

    assign rtype = cls.addu | cls.subu | cls.slt;

    // ALU setup for the current instruction; driven from EXEC through WB so the
    // ALU result seen by MEM/WB does not move.
    always_comb begin
        alu_op_i = ALU_ADD;
        if (cls.subu | cls.slt | cls.beq) alu_op_i = ALU_SUB;
        else if (cls.ori)                 alu_op_i = ALU_OR;
        else if (cls.lui)                 alu_op_i = ALU_LUI;
    end
    assign alu_b_i = cls.lw | cls.sw | cls.ori | cls.lui;
    assign ext_i   = cls.lw | cls.sw | cls.beq;

    always_comb begin
        state_nxt     = FETCH;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.npc_sel   = NPC_PC4;
        bus.reg_we    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.wd_sel    = WD_ALU;
        bus.wa_sel    = WA_RT;
        bus.alu_b_sel = 1'b0;
        bus.ext_sel   = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.illegal   = 1'b0;

        case (state)
            FETCH: begin
                bus.ir_we = 1'b1;
                bus.pc_we = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                if (!legal) begin
                    bus.illegal = 1'b1;
                end else if (cls.j | cls.jal) begin
                    bus.pc_we   = 1'b1;
                    bus.npc_sel = NPC_JUMP;
                    if (cls.jal) begin
                        // PC register still holds PC+4 here: that is the link value.
                        bus.reg_we = 1'b1;
                        bus.wa_sel = WA_R31;
                        bus.wd_sel = WD_PC;
                    end
                end else if (cls.jr) begin
                    bus.pc_we   = 1'b1;
                    bus.npc_sel = NPC_RS;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                bus.alu_op    = alu_op_i;
                bus.alu_b_sel = alu_b_i;
                bus.ext_sel   = ext_i;
                if (cls.beq) begin
                    bus.npc_sel = NPC_BR;
                    bus.pc_we   = bus.zero;
                end else if (cls.lw | cls.sw) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                bus.alu_op    = alu_op_i;
                bus.alu_b_sel = alu_b_i;
                bus.ext_sel   = ext_i;
                if (cls.sw) bus.mem_we = 1'b1;
                else        state_nxt  = WB;
            end
            WB: begin
                bus.alu_op    = alu_op_i;
                bus.alu_b_sel = alu_b_i;
                bus.ext_sel   = ext_i;
                bus.reg_we    = 1'b1;
                bus.wa_sel    = rtype ? WA_RD : WA_RT;
                if (cls.slt)     bus.wd_sel = WD_LESS;
                else if (cls.lw) bus.wd_sel = WD_MEM;
            end
            default: state_nxt = FETCH;
        endcase

        // Reset silences everything so an aborted instruction leaves no trace.
        if (reset) begin
            bus.ir_we     = 1'b0;
            bus.pc_we     = 1'b0;
            bus.npc_sel   = NPC_PC4;
            bus.reg_we    = 1'b0;
            bus.mem_we    = 1'b0;
            bus.wd_sel    = WD_ALU;
            bus.wa_sel    = WA_RT;
            bus.alu_b_sel = 1'b0;
            bus.ext_sel   = 1'b0;
            bus.alu_op    = ALU_ADD;
            bus.illegal   = 1'b0;
        end
    end

    // Last cycle of a legal instruction: any return to FETCH except an illegal DECODE.
    assign retire = (state != FETCH) && (state_nxt == FETCH) && legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.retired = retired_q;
endmodule
